ps2_packet_tx: RTL and testbench

//  Generates 3-byte PS/2 mouse movement packets for the byte-stream parser. One motion

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_axis_encode.sv | 21 ++
 rtl/ps2_packet_tx.sv | 126 ++++++++++++
 tb/tb_ps2_packet_tx.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse packet generator and the byte-stream parser.
// The parser reads the same byte-1 bit positions, so they are defined once, here.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BYTE1,
        ST_BYTE2,
        ST_BYTE3,
        ST_WAIT
    } state_t;

    // Bit positions inside packet byte 1.
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XO    = 6;
    localparam int YO    = 7;

    localparam int PKT_BYTES = 3;

    // btn is {middle, right, left}. The sync bit is always set so the parser can frame the stream.
    function automatic logic [7:0] make_byte1(
        input logic [2:0] btn,
        input logic       x_ovf,
        input logic       y_ovf,
        input logic       x_sign,
        input logic       y_sign
    );
        logic [7:0] b;
        b        = '0;
        b[BTN_L] = btn[0];
        b[BTN_R] = btn[1];
        b[BTN_M] = btn[2];
        b[SYNC]  = 1'b1;
        b[XS]    = x_sign;
        b[YS]    = y_sign;
        b[XO]    = x_ovf;
        b[YO]    = y_ovf;
        return b;
    endfunction

endpackage

// File: rtl/ps2_axis_encode.sv
// Converts one 16-bit signed displacement to the 9-bit PS/2 axis value and its overflow flag.
// Purely combinational. The top level instantiates one per axis.
module ps2_axis_encode #(
    parameter bit SAT = 1'b1
) (
    input  logic [15:0] value,
    output logic        ovf,
    output logic [8:0]  enc
);

    // A value fits in 9-bit two's complement only if bits [15:8] all equal the new sign bit.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        ovf = (value[15:8] != {8{value[8]}});
        enc = value[8:0];
        if (SAT && ovf) begin
            enc = value[15] ? 9'h100 : 9'h0FF;
        end
    end

endmodule

// File: rtl/ps2_packet_tx.sv
// Accepts one motion sample per handshake and emits it as a 3-byte PS/2 mouse packet.
// All outputs are registered. No combinational path exists from inputs to outputs.
module ps2_packet_tx
    import ps2_pkg::*;
#(
    parameter int GAP = 0,
    parameter bit SAT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_btn,
    input  logic [15:0] in_dx,
    input  logic [15:0] in_dy,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_first,
    output logic        out_last,
    output logic [15:0] pkt_count
);

    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t     state;
    logic [3:0] gap_cnt;
    logic [7:0] byte2_q;
    logic [7:0] byte3_q;

    logic       x_ovf;
    logic       y_ovf;
    logic [8:0] x_v;
    logic [8:0] y_v;
    logic [7:0] byte1_d;

    ps2_axis_encode #(.SAT(SAT)) u_enc_x (
        .value (in_dx),
        .ovf   (x_ovf),
        .enc   (x_v)
    );

    ps2_axis_encode #(.SAT(SAT)) u_enc_y (
        .value (in_dy),
        .ovf   (y_ovf),
        .enc   (y_v)
    );

    assign byte1_d = make_byte1(in_btn, x_ovf, y_ovf, x_v[8], y_v[8]);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_byte  <= 8'h00;
            byte2_q   <= 8'h00;
            byte3_q   <= 8'h00;
            gap_cnt   <= 4'd0;
            pkt_count <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The sample is encoded and captured here. Later input changes do not affect this packet.
                    if (in_valid) begin
                        out_byte  <= byte1_d;
                        byte2_q   <= x_v[7:0];
                        byte3_q   <= y_v[7:0];
                        out_valid <= 1'b1;
                        out_first <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= ST_BYTE1;
                    end
                end
                ST_BYTE1: begin
                    if (out_ready) begin
                        out_byte  <= byte2_q;
                        out_first <= 1'b0;
                        state     <= ST_BYTE2;
                    end
                end
                ST_BYTE2: begin
                    if (out_ready) begin
                        out_byte <= byte3_q;
                        out_last <= 1'b1;
                        state    <= ST_BYTE3;
                    end
                end
                ST_BYTE3: begin
                    if (out_ready) begin
                        out_byte  <= 8'h00;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        pkt_count <= pkt_count + 16'd1;
                        if (GAP == 0) begin
                            in_ready <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (gap_cnt == 4'd0) begin
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_first <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_packet_tx.sv
// Scoreboard bench for ps2_packet_tx: DUTs a (SAT=1) and b (SAT=0) share stimulus, and DUT c (GAP=3)
// checks packet spacing. Expected bytes are queued when a sample is issued and popped by monitors.
module tb_ps2_packet_tx;
    import ps2_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_btn = '0;
    logic [15:0] in_dx = '0;
    logic [15:0] in_dy = '0;
    logic        out_ready = 1'b1;

    logic        in_ready_a, out_valid_a, out_first_a, out_last_a;
    logic [7:0]  out_byte_a;
    logic [15:0] pkt_count_a;
    logic        in_ready_b, out_valid_b, out_first_b, out_last_b;
    logic [7:0]  out_byte_b;
    logic [15:0] pkt_count_b;
    logic        in_valid_c = 1'b0;
    logic        out_ready_c = 1'b1;
    logic        in_ready_c, out_valid_c, out_first_c, out_last_c;
    logic [7:0]  out_byte_c;
    logic [15:0] pkt_count_c;

    ps2_packet_tx #(.GAP(0), .SAT(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_btn(in_btn), .in_dx(in_dx), .in_dy(in_dy), .out_byte(out_byte_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_first(out_first_a),
        .out_last(out_last_a), .pkt_count(pkt_count_a)
    );

    ps2_packet_tx #(.GAP(0), .SAT(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_btn(in_btn), .in_dx(in_dx), .in_dy(in_dy), .out_byte(out_byte_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_first(out_first_b),
        .out_last(out_last_b), .pkt_count(pkt_count_b)
    );

    ps2_packet_tx #(.GAP(3), .SAT(1'b1)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_btn(in_btn), .in_dx(in_dx), .in_dy(in_dy), .out_byte(out_byte_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_first(out_first_c),
        .out_last(out_last_c), .pkt_count(pkt_count_c)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard entries are {first, last, byte}.
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];

    task automatic push_pkt(input logic [23:0] ea, input logic [23:0] eb);
        exp_a.push_back({2'b10, ea[23:16]});
        exp_a.push_back({2'b00, ea[15:8]});
        exp_a.push_back({2'b01, ea[7:0]});
        exp_b.push_back({2'b10, eb[23:16]});
        exp_b.push_back({2'b00, eb[15:8]});
        exp_b.push_back({2'b01, eb[7:0]});
    endtask

    // Reference encoding done with integer range tests rather than bit patterns.
    function automatic logic [23:0] enc_model(input logic [2:0] btn, input logic [15:0] dx,
                                              input logic [15:0] dy, input bit sat);
        int xi, yi;
        bit xo, yo;
        logic [8:0] xv, yv;
        xi = $signed(dx);
        yi = $signed(dy);
        xo = (xi > 255) || (xi < -256);
        yo = (yi > 255) || (yi < -256);
        xv = dx[8:0];
        yv = dy[8:0];
        if (sat && xo) xv = (xi < 0) ? 9'h100 : 9'h0FF;
        if (sat && yo) yv = (yi < 0) ? 9'h100 : 9'h0FF;
        return {yo, xo, yv[8], xv[8], 1'b1, btn, xv[7:0], yv[7:0]};
    endfunction

    // Monitor for DUT a plus a minimal stream parser that frames on the sync bit.
    int p_idx = 0;
    int p_done = 0;
    always @(negedge clk) begin
        if (reset) begin
            p_idx = 0;
        end else if (out_valid_a === 1'b1 && out_ready) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mon_a: got unexpected byte %0h, expected none", out_byte_a);
            end else begin
                check("mon_a", {out_first_a, out_last_a, out_byte_a}, exp_a.pop_front());
            end
            if (out_first_a) begin
                check("parser_sync", out_byte_a[SYNC], 1'b1);
                p_idx = 1;
            end else if (p_idx == 1 || p_idx == 2) begin
                p_idx++;
            end
            if (out_last_a && p_idx == PKT_BYTES) begin
                p_done++;
                p_idx = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid_b === 1'b1 && out_ready) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mon_b: got unexpected byte %0h, expected none", out_byte_b);
            end else begin
                check("mon_b", {out_first_b, out_last_b, out_byte_b}, exp_b.pop_front());
            end
        end
    end

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Holds in_valid until in_ready is seen before an edge, then scrambles the inputs.
    task automatic send(input logic [2:0] b, input logic [15:0] x, input logic [15:0] y);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_btn = b;
        in_dx = x;
        in_dy = y;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = (in_ready_a === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_btn = 3'($urandom);
        in_dx = 16'($urandom);
        in_dy = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp_a.size() + exp_b.size(), 0);
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] edges [8];
        edges = '{16'd255, 16'd256, 16'hFF00, 16'hFEFF, 16'd0, 16'hFFFF, 16'h7FFF, 16'h8000};
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return edges[$urandom_range(0, 7)];
            default: return 16'(int'($urandom_range(0, 600)) - 300);
        endcase
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        int firsts[$];
        int cyc, wait_left, leak;
        logic [2:0]  b;
        logic [15:0] x, y;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_a", {in_ready_a, out_valid_a, out_first_a, out_last_a, out_byte_a, pkt_count_a},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0});
        check("reset_b", {in_ready_b, out_valid_b, pkt_count_b}, {1'b1, 1'b0, 16'd0});
        check("reset_c", {in_ready_c, out_valid_c, pkt_count_c}, {1'b1, 1'b0, 16'd0});
        @(posedge clk);
        #1;

        // Basic packet: left button, dx=5, dy=-3.
        push_pkt({8'h29, 8'h05, 8'hFD}, {8'h29, 8'h05, 8'hFD});
        send(3'b001, 16'd5, 16'hFFFD);
        drain();
        check("count_after_1", pkt_count_a, 16'd1);

        // dx=300, dy=-1000. Without saturation 300 keeps 9'h12C, so XS is set as well.
        push_pkt({8'hE8, 8'hFF, 8'h00}, {8'hD8, 8'h2C, 8'h18});
        send(3'b000, 16'd300, 16'hFC18);
        drain();

        // Backpressure while byte 2 is presented.
        push_pkt({8'h1E, 8'hFF, 8'h64}, {8'h1E, 8'hFF, 8'h64});
        send(3'b110, 16'hFFFF, 16'd100);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold", {out_valid_a, out_first_a, out_last_a, out_byte_a},
                  {1'b1, 1'b0, 1'b0, 8'hFF});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {out_valid_a, out_byte_a}, {1'b1, 8'hFF});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("byte3_next", {out_valid_a, out_last_a, out_byte_a}, {1'b1, 1'b1, 8'h64});
        drain();
        check("count_after_3", pkt_count_a, 16'd3);

        // Reset while byte 2 is waiting.
        push_pkt({8'h29, 8'h05, 8'hFD}, {8'h29, 8'h05, 8'hFD});
        send(3'b001, 16'd5, 16'hFFFD);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("pre_reset", {pkt_count_a, out_valid_a, out_byte_a}, {16'd3, 1'b1, 8'h05});
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_a.delete();
        exp_b.delete();
        @(negedge clk);
        check("reset_mid", {out_valid_a, in_ready_a, pkt_count_a}, {1'b0, 1'b1, 16'd0});
        out_ready = 1'b1;
        leak = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_a !== 1'b0) leak++;
        end
        check("no_partial", leak, 0);
        @(posedge clk);
        #1;

        // Random samples through both DUTs with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            b = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            push_pkt(enc_model(b, x, y, 1'b1), enc_model(b, x, y, 1'b0));
            send(b, x, y);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        check("parser_done", p_done, 1003);
        check("count_rand_a", pkt_count_a, 16'd1000);
        check("count_rand_b", pkt_count_b, 16'd1000);

        // GAP=3 with in_valid held high: byte 1 every 7 cycles, in_ready low in WAIT.
        in_btn = 3'b001;
        in_dx = 16'd5;
        in_dy = 16'hFFFD;
        in_valid_c = 1'b1;
        cyc = 0;
        wait_left = 0;
        repeat (40) begin
            @(negedge clk);
            cyc++;
            if (out_valid_c === 1'b1) begin
                if (out_first_c) begin
                    firsts.push_back(cyc);
                    check("c_byte1", out_byte_c, 8'h29);
                end
                if (out_last_c) wait_left = 3;
            end else if (wait_left > 0) begin
                check("c_wait_busy", in_ready_c, 1'b0);
                wait_left--;
            end
        end
        in_valid_c = 1'b0;
        check("c_packets", firsts.size() >= 3, 1'b1);
        if (firsts.size() >= 3) begin
            for (int i = 1; i < 3; i++) check("c_period", firsts[i] - firsts[i-1], 7);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
